// File: rtl/ddr_pattern_pkg.sv
// Shared types, mode codes and the PRBS7 stepping helper for the
// multi-lane OSERDES pattern generator.
package ddr_pattern_pkg;

  localparam logic [2:0] MODE_ZERO  = 3'd0;
  localparam logic [2:0] MODE_CLOCK = 3'd1;
  localparam logic [2:0] MODE_COUNT = 3'd2;
  localparam logic [2:0] MODE_PRBS  = 3'd3;
  localparam logic [2:0] MODE_TRAIN = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RSTH,
    ST_SETTLE,
    ST_RUN
  } state_e;

  localparam int PRBS_W     = 7;
  localparam int PRBS_TAP_A = 6;
  localparam int PRBS_TAP_B = 5;
  localparam int MAX_BITS   = 10;

  typedef struct packed {
    logic [PRBS_W-1:0]   st;
    logic [MAX_BITS-1:0] bits;
  } prbs_res_t;

  // x^7+x^6+1 Fibonacci; the MSB leaves first and lands in bit 0
  function automatic prbs_res_t prbs7_step_n(
    input logic [PRBS_W-1:0] st,
    input int                n
  );
    prbs_res_t         r;
    logic [PRBS_W-1:0] s;
    s      = st;
    r.bits = '0;
    for (int i = 0; i < MAX_BITS; i++) begin
      if (i < n) begin
        r.bits[i] = s[PRBS_W-1];
        s = {s[PRBS_W-2:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
      end
    end
    r.st = s;
    return r;
  endfunction

endpackage

// File: rtl/ddr_prbs7_lane.sv
// One PRBS7 lane: seed load on RUN entry, i2o steps per advanced word,
// word bits are the bits shifted out of the current state.
module ddr_prbs7_lane
  import ddr_pattern_pkg::*;
#(
  parameter int i2o = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [PRBS_W-1:0] seed_i,
  input  logic              load_i,
  input  logic              adv_i,
  output logic [i2o-1:0]    bits_o
);

  logic [PRBS_W-1:0]   lfsr_q;
  logic [PRBS_W-1:0]   cur;
  prbs_res_t           res;
  logic [MAX_BITS-1:0] unused_bits;

  assign cur         = load_i ? seed_i : lfsr_q;
  assign res         = prbs7_step_n(cur, i2o);
  assign bits_o      = res.bits[i2o-1:0];
  assign unused_bits = res.bits;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= '1;
    end else if (load_i || adv_i) begin
      lfsr_q <= res.st;
    end
  end

endmodule

// File: rtl/ddr_lane_pattern_gen.sv
// Multi-lane OSERDES pattern source: SR sequencing against DCM lock, then
// zero/clock/count/PRBS7/train words. DDR_PATTERN_ERRINJ_EN adds errInj.
module ddr_lane_pattern_gen
  import ddr_pattern_pkg::*;
#(
  parameter int             nLanes       = 4,
  parameter int             i2o          = 4,
  parameter int             rstCycles    = 8,
  parameter int             settleCycles = 4,
  parameter logic [i2o-1:0] trainWord    = i2o'(4'b0110)
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    dcmLocked,
  input  logic                    enable,
  input  logic [2:0]              mode,
`ifdef DDR_PATTERN_ERRINJ_EN
  input  logic                    errInj,
`endif
  output logic                    rstSerdes,
  output logic [nLanes*i2o-1:0]   laneData,
  output logic                    running,
  output logic [31:0]             wordCount
);

  localparam int DW = nLanes * i2o;

  generate
    if (nLanes < 1 || nLanes > 127) begin : g_bad_lanes
      $error("nLanes must be 1..127");
    end
    if (i2o < 2 || i2o > 10) begin : g_bad_i2o
      $error("i2o must be 2..10");
    end
    if (rstCycles < 1 || settleCycles < 1) begin : g_bad_cyc
      $error("rstCycles and settleCycles must be >= 1");
    end
  endgenerate

  logic           sync1_q, sync2_q;
  logic           ok;
  state_e         state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [2:0]     modeR_q, modeR_d, modeSel;
  logic [i2o-1:0] pc_q, pc_d, pcCur;
  logic           entering, inRun;
  logic [DW-1:0]  laneData_q, laneData_d;
  logic           rstSerdes_q, rstSerdes_d;
  logic           running_q, running_d;
  logic [31:0]    wordCount_q, wordCount_d;
  logic [DW-1:0]  clkAll, cntAll, prbsAll, trainAll;

  assign ok = sync2_q & enable;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!ok) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_RSTH;
          cnt_d   = 16'(rstCycles - 1);
        end
        ST_RSTH: begin
          if (cnt_q == '0) begin
            state_d = ST_SETTLE;
            cnt_d   = 16'(settleCycles - 1);
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) state_d = ST_RUN;
          else cnt_d = cnt_q - 16'd1;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  assign inRun    = (state_d == ST_RUN);
  assign entering = inRun && (state_q != ST_RUN);
  assign modeSel  = entering ? mode : modeR_q;
  assign modeR_d  = modeSel;
  assign pcCur    = entering ? '0 : pc_q;
  assign pc_d     = inRun ? pcCur + 1'b1 : pc_q;
  assign trainAll = {nLanes{trainWord}};

  for (genvar k = 0; k < nLanes; k++) begin : g_lane
    for (genvar b = 0; b < i2o; b++) begin : g_bit
      assign clkAll[k*i2o+b] = (b % 2 == 0);
    end
    assign cntAll[k*i2o +: i2o] = pcCur + i2o'(k);
    ddr_prbs7_lane #(.i2o(i2o)) u_prbs (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .seed_i (7'h7F ^ 7'(k)),
      .load_i (entering),
      .adv_i  (inRun && !entering),
      .bits_o (prbsAll[k*i2o +: i2o])
    );
  end

`ifdef DDR_PATTERN_ERRINJ_EN
  logic errInj_q;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) errInj_q <= 1'b0;
    else errInj_q <= errInj;
  end
`endif

  always_comb begin
    laneData_d = '0;
    if (inRun) begin
      unique case (1'b1)
        (modeSel == MODE_CLOCK): laneData_d = clkAll;
        (modeSel == MODE_COUNT): laneData_d = cntAll;
        (modeSel == MODE_PRBS):  laneData_d = prbsAll;
        (modeSel == MODE_TRAIN): laneData_d = trainAll;
        default:                 laneData_d = '0;
      endcase
`ifdef DDR_PATTERN_ERRINJ_EN
      // corrupt only the emitted word; pattern state is untouched
      if (errInj && !errInj_q) laneData_d[0] = ~laneData_d[0];
`endif
    end
  end

  always_comb begin
    wordCount_d = wordCount_q;
    if (entering) begin
      wordCount_d = 32'd1;
    end else if (inRun && wordCount_q != 32'hFFFF_FFFF) begin
      wordCount_d = wordCount_q + 32'd1;
    end
  end

  assign rstSerdes_d = (state_d == ST_IDLE) || (state_d == ST_RSTH);
  assign running_d   = inRun;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      modeR_q     <= MODE_ZERO;
      pc_q        <= '0;
      laneData_q  <= '0;
      rstSerdes_q <= 1'b1;
      running_q   <= 1'b0;
      wordCount_q <= '0;
    end else begin
      sync1_q     <= dcmLocked;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      modeR_q     <= modeR_d;
      pc_q        <= pc_d;
      laneData_q  <= laneData_d;
      rstSerdes_q <= rstSerdes_d;
      running_q   <= running_d;
      wordCount_q <= wordCount_d;
    end
  end

  assign laneData  = laneData_q;
  assign rstSerdes = rstSerdes_q;
  assign running   = running_q;
  assign wordCount = wordCount_q;

endmodule

// File: doc/ddr_lane_pattern_gen.md
Name: ddr_lane_pattern_gen

Overview:
- Parametrised multi-lane pattern source for OSERDES-based DDR output links; generalises the single-lane lock-status shift-register test driver.
- Runs in the SDR (CLKDIV) domain and drives the D1..Dn inputs of nLanes OSERDES plus their shared SR.
- Sequences SERDES reset against DCM lock, then emits a selectable pattern (zero, clock, counter, PRBS7, training word) for link bring-up and constraint/timing debug.

Parameters:
- nLanes, 4, number of OSERDES lanes driven.
- i2o, 4, serialisation ratio (bits per lane per CLK); legal values 2..10.
- rstCycles, 8, CLK cycles rstSerdes is held high after lock/enable.
- settleCycles, 4, CLK cycles of all-zero data after rstSerdes falls and before pattern starts.
- trainWord, 4'b0110, i2o-bit training word; the same value is driven on all lanes.

Ports:
- CLK, in, 1: SDR clock (OSERDES CLKDIV).
- RST_N, in, 1: asynchronous active-low reset.
- dcmLocked, in, 1: DCM LOCKED, asynchronous; double-flop synchronised internally.
- enable, in, 1: level; high requests pattern output.
- mode, in, 3: pattern select, sampled on entry to RUN.
- rstSerdes, out, 1: OSERDES SR, active high.
- laneData, out, nLanes*i2o: lane k occupies bits [k*i2o +: i2o]; bit 0 maps to D1 and is serialised first.
- running, out, 1: high while in RUN.
- wordCount, out, 32: number of RUN words emitted.

Behaviour:
- Reset (RST_N low, asynchronous): rstSerdes=1, laneData=0, running=0, wordCount=0, state=IDLE, lock synchroniser=0.
- lockS is dcmLocked after 2 synchroniser flops.
- FSM states:
  - IDLE: rstSerdes=1, laneData=0. Goes to RSTH when lockS && enable.
  - RSTH: rstSerdes=1 for exactly rstCycles cycles, then SETTLE.
  - SETTLE: rstSerdes=0, laneData=0 for settleCycles cycles, then RUN. modeR <= mode on the transition.
  - RUN: running=1 and laneData is registered pattern output. The first pattern word appears in the first RUN cycle.
- Lock loss (lockS=0) in any state: next cycle goes to IDLE, rstSerdes=1, laneData=0, running=0. wordCount holds its value.
- enable=0 in any non-IDLE state: goes to IDLE the same way. If lock loss and enable drop together, there is a single IDLE transition.
- The cycle counter is shared by RSTH and SETTLE and reloads on each state entry.
- Re-entry into RUN clears wordCount to 1 on the first RUN word. wordCount then increments once per RUN cycle and saturates at 32'hFFFF_FFFF.
- mode changes while in RUN are ignored until the next pass through IDLE.
- Mode encodings:
  - 0 ZERO: all zeros.
  - 1 CLOCK: even bit positions 1, odd bit positions 0 (serial stream 1010...).
  - 2 COUNT: lane k = (cnt + k) mod 2^i2o. cnt starts at 0 in the first RUN cycle and increments per word.
  - 3 PRBS7: x^7+x^6+1, Fibonacci. Lane k is seeded with 7'h7F ^ k[6:0] on RUN entry. Each word advances the LFSR i2o steps; the bit shifted out first lands in bit 0.
  - 4 TRAIN: trainWord on every lane, every cycle.
  - 5-7: treated as ZERO.
- An all-zero PRBS state cannot occur: seeds are nonzero for nLanes<=127, and nLanes>127 is illegal (elaboration error).

Optional Feature:
- Macro DDR_PATTERN_ERRINJ_EN.
- With the macro: adds input errInj (1 bit). A rising edge detected in RUN inverts bit 0 of lane 0 for exactly one output word. Only the output is corrupted; LFSR and counter state are unaffected. errInj outside RUN is ignored.
- Without the macro: no errInj port and no inversion logic.

Decomposition:
- Package ddr_pattern_pkg holds:
  - mode encodings (MODE_ZERO..MODE_TRAIN);
  - FSM state enum;
  - PRBS7 tap constants;
  - function prbs7_step_n(state, n) returning next state and n output bits.
- One sub-module, ddr_prbs7_lane: a single-lane LFSR with seed load, advance enable and i2o-bit output. It is instantiated nLanes times with a generate loop.

Test Plan:
- RST_N released, dcmLocked=1, enable=1, defaults:
  - rstSerdes high through 2 sync cycles + 8 RSTH cycles;
  - then 4 SETTLE cycles with laneData=0;
  - running rises on the next cycle.
- mode=2, nLanes=4, i2o=4: first RUN word is lanes {3,2,1,0}={3,2,1,0}; after 15 words lane 0=4'hF, and the next word is 0 (wrap); wordCount=16.
- mode=3: lane 0 words match the reference LFSR model seeded 7'h7F for 127 words; the sequence repeats at word 128; lane 1 is seeded 7'h7E.
- dcmLocked dropped mid-RUN: after 2 sync cycles plus 1, rstSerdes=1, laneData=0 and wordCount is held. Restoring lock repeats the full RSTH/SETTLE sequence and wordCount restarts at 1.
- mode=4, with mode switched to 1 during RUN: output stays 4'b0110 on all lanes. After an enable toggle, output is 4'b0101 per lane.
- DDR_PATTERN_ERRINJ_EN defined, mode=1, errInj pulsed in RUN: exactly one word has lane 0 = 4'b0100; the neighbouring words are 4'b0101.
